// File: rtl/rom_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, drives the ROM address, captures the
// ROM's registered read data and buffers bytes in a small prefetch queue for the decoder.
module rom_fetch_unit #(
  parameter int                    ADDR_WIDTH   = 8,
  parameter int                    QUEUE_DEPTH  = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 8'h00
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  output logic [ADDR_WIDTH-1:0] ROM_ADDR,
  input  logic [7:0]            ROM_DATA,
  output logic [7:0]            INSTR_DATA,
  output logic [ADDR_WIDTH-1:0] INSTR_ADDR,
  output logic                  INSTR_VALID,
  input  logic                  INSTR_READY,
  input  logic                  JUMP,
  input  logic [ADDR_WIDTH-1:0] JUMP_ADDR
);

  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [7:0]            data;
    logic [ADDR_WIDTH-1:0] addr;
  } entry_t;

  entry_t                q [QUEUE_DEPTH];
  entry_t                head;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] inflight_addr;
  logic                  inflight_valid;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         count;
  logic [CW:0]           occupancy;
  logic                  issue;
  logic                  push;
  logic                  pop;

  // Occupancy includes the byte still in the ROM pipe, so the queue cannot overflow
  // even though a same-cycle pop is not credited.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight_valid};
  assign issue     = !JUMP && (occupancy < (CW+1)'(QUEUE_DEPTH));
  assign push      = inflight_valid && !JUMP;
  assign pop       = INSTR_VALID && INSTR_READY && !JUMP;

  assign ROM_ADDR    = fetch_pc;
  assign head        = q[rd_ptr];
  assign INSTR_DATA  = head.data;
  assign INSTR_ADDR  = head.addr;
  assign INSTR_VALID = (count != '0);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      fetch_pc       <= RESET_VECTOR;
      inflight_valid <= 1'b0;
      inflight_addr  <= '0;
    end else if (JUMP) begin
      fetch_pc       <= JUMP_ADDR;
      inflight_valid <= 1'b0;
    end else if (issue) begin
      fetch_pc       <= fetch_pc + ADDR_WIDTH'(1);
      inflight_valid <= 1'b1;
      inflight_addr  <= fetch_pc;
    end else begin
      inflight_valid <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) q[i] <= '0;
    end else if (push) begin
      q[wr_ptr] <= '{data: ROM_DATA, addr: inflight_addr};
    end
  end

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (JUMP) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
